// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: occupancy states and the all-zero bubble word.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    // One bit of the NOP encoding; replicated to whatever payload width a stage carries.
    localparam logic NOP_WORD = 1'b0;

endpackage

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid buffer.
// Optional saturating stall counter enabled by PIPE_STAGE_STALL_CNT_EN.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,output logic [CNT_W-1:0] stall_cnt
`endif
);

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic              push;
    logic              pop;
    state_t            cur_state;

    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign push      = in_valid & ~skid_valid;
    assign pop       = main_valid & out_ready;

    always_comb begin
        cur_state = EMPTY;
        if (skid_valid)
            cur_state = SKID;
        else if (main_valid)
            cur_state = FULL;
    end

    // Data is zeroed whenever a register empties so out_data reads as a NOP bubble.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            main_valid <= 1'b0;
            main_data  <= {DATA_W{NOP_WORD}};
            skid_valid <= 1'b0;
            skid_data  <= {DATA_W{NOP_WORD}};
        end else begin
            unique case (cur_state)
                EMPTY: begin
                    if (push) begin
                        main_valid <= 1'b1;
                        main_data  <= in_data;
                    end
                end
                FULL: begin
                    if (pop && push) begin
                        main_data <= in_data;
                    end else if (pop) begin
                        main_valid <= 1'b0;
                        main_data  <= {DATA_W{NOP_WORD}};
                    end else if (push) begin
                        skid_valid <= 1'b1;
                        skid_data  <= in_data;
                    end
                end
                SKID: begin
                    if (pop) begin
                        main_data  <= skid_data;
                        skid_valid <= 1'b0;
                        skid_data  <= {DATA_W{NOP_WORD}};
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PIPE_STAGE_STALL_CNT_EN
    // Survives flush on purpose so stall statistics span pipeline redirects.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (main_valid && !out_ready && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + 1'b1;
    end
`endif

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

- Parametrised pipeline stage register with a valid/ready handshake and a one-entry skid buffer.
- Replaces the fixed freeze/flush stage registers between pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Upstream stalls are derived from `in_ready`, so no combinational path runs from `out_ready` to `in_ready`.
- Flush inserts a zero bubble, preserving the all-zero NOP convention.

## Interface
Parameters:
- DATA_W, 64, payload width (e.g. PC + instruction)
- CNT_W, 16, stall counter width (used only with the counter macro)

Ports:
- clk  input  1  clock; all state updates on its rising edge
- rst  input  1  reset, synchronous, active-high
- flush  input  1  discard all held and incoming data this cycle
- in_valid  input  1  upstream offers in_data
- in_ready  output  1  stage can accept; registered
- in_data  input  DATA_W  upstream payload
- out_valid  output  1  out_data is valid; registered
- out_ready  input  1  downstream accepts out_data (0 = freeze)
- out_data  output  DATA_W  payload; all-zero whenever out_valid=0
- stall_cnt  output  CNT_W  present only with PIPE_STAGE_STALL_CNT_EN

## Operation
- Storage:
  - main register (data + valid) drives the outputs
  - skid register (data + valid) catches one beat while out_ready=0
- States, encoded by the valid bits:
  - EMPTY: main=0, skid=0
  - FULL: main=1, skid=0
  - SKID: main=1, skid=1
- Handshake rules:
  - push = in_valid & in_ready
  - pop = out_valid & out_ready
- in_ready = ~skid_valid. Derived from a flop only: 1 in EMPTY and FULL, 0 in SKID.
- Transitions when flush=0:
  - EMPTY: push → FULL, main←in_data; otherwise stay.
  - FULL, pop & push → FULL, main←in_data.
  - FULL, pop & ~push → EMPTY, main data←0.
  - FULL, ~pop & push → SKID, skid←in_data.
  - FULL, ~pop & ~push → hold.
  - SKID, pop → FULL, main←skid, skid data←0; in_data is ignored (in_ready=0).
  - SKID, ~pop → hold.
- Flush (priority below rst, above everything else):
  - next state EMPTY; main and skid data←0.
  - A push or pop in the flush cycle has no effect on stored state.
  - in_ready=1 on the following cycle.
- Ordering: beats leave in arrival order. No beat is duplicated or dropped except by flush.
- Payload is opaque; there is no width conversion.

## Timing
- Reset values:
  - out_valid=0, out_data=0, in_ready=1
  - skid empty, stall_cnt=0
- Latency: in_data accepted at edge N appears on out_data after edge N (one cycle).
- Throughput: one beat per cycle with out_ready held high.
- Freeze: out_ready=0 with out_valid=1 holds out_data stable. One further beat is absorbed, then in_ready drops on the next cycle.
- Unfreeze from SKID: the skid beat appears one cycle after the pop. in_ready rises in the same cycle.
- Simultaneous rst and flush: rst wins; the result is identical either way.
- out_valid/out_data must not depend combinationally on any input.
- in_ready must not depend combinationally on any input.

## Configuration
- PIPE_STAGE_STALL_CNT_EN
- Defined:
  - stall_cnt increments each cycle with out_valid=1 & out_ready=0.
  - Saturates at all-ones.
  - Cleared only by rst; flush does not clear it.
- Undefined: the stall_cnt port and its logic do not exist; all other behaviour is identical.

## Structure
- Shared package pipe_pkg:
  - state enum {EMPTY, FULL, SKID} for debug/assertions
  - NOP_WORD constant (zero) used for bubbles
- Single module. No sub-module: main and skid entries are two instances of the same few flops, not worth a separate block.

## Test plan
- Stream 0x1..0x8 with out_ready=1 → out_data 0x1..0x8 on consecutive cycles, one cycle late; in_ready constant 1.
- Load 0xA; out_ready=0; offer 0xB, 0xC → 0xB taken, in_ready=0 next cycle, 0xC held upstream; out_ready=1 → outputs 0xA, 0xB, 0xC in order.
- SKID state (0xA main, 0xB skid) plus flush → next cycle out_valid=0, out_data=0, in_ready=1; 0xA and 0xB never appear.
- flush asserted with in_valid=1, in_data=0x55 → 0x55 discarded, out_valid=0 next cycle.
- rst asserted mid-stream in SKID state → after the edge all outputs at reset values; first post-reset beat passes with one-cycle latency.
- With PIPE_STAGE_STALL_CNT_EN and CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles → stall_cnt=15 and held; flush leaves 15; rst → 0.
